move_sequencer: RTL and testbench

Controller that sequences one 2048 move over the 4x4 tile grid: accepts a one-hot direction, slides and merges one line per cycle, spawns a new tile from an LFSR, then classifies the game as playing, won or lost. It owns the grid register and the game status, and sits between the debounced button/direction logic and the display renderer. A load port lets the bench, or a future save/restore block, preset the board.

---
 rtl/move_sequencer_if.sv | 22 ++
 rtl/move_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_move_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/move_sequencer_if.sv
// Board/move bus between the input logic, the move sequencer and the renderer.
// The master side drives requests; the slave side owns the board and status.
interface move_sequencer_if;
   logic [3:0]       direction;
   logic             load;
   logic [15:0][3:0] load_grid;
   logic [15:0][3:0] grid;
   logic [1:0]       state;
   logic             busy;
   logic             move_done;
   logic             moved;

   modport master (
      output direction, load, load_grid,
      input  grid, state, busy, move_done, moved
   );

   modport slave (
      input  direction, load, load_grid,
      output grid, state, busy, move_done, moved
   );
endinterface

// File: rtl/move_sequencer.sv
// 2048 move sequencer: slides one line per cycle, spawns a tile from an
// LFSR, then classifies the board as playing, won or lost.
module move_sequencer (
   input  logic            clk,
   input  logic            rst,
   move_sequencer_if.slave bus
);
   typedef enum logic [2:0] {
      INIT0, INIT1, IDLE, SLIDE, SPAWN, CHECK
   } fsm_t;

   localparam logic [3:0]  WIN     = 4'd11;
   localparam logic [15:0] SEED    = 16'hACE1;
   localparam logic [1:0]  PLAYING = 2'b00;
   localparam logic [1:0]  WON     = 2'b01;
   localparam logic [1:0]  LOST    = 2'b10;

   fsm_t             fsm;
   logic [15:0][3:0] grid;
   logic [1:0]       status;
   logic             busy;
   logic             move_done;
   logic             moved;
   logic             armed;
   logic             changed;
   logic             from_move;
   logic [15:0]      lfsr;
   logic [3:0]       dir;
   logic [1:0]       k;

   assign bus.grid      = grid;
   assign bus.state     = status;
   assign bus.busy      = busy;
   assign bus.move_done = move_done;
   assign bus.moved     = moved;

   function automatic logic [3:0][3:0] slide_line(
      input logic [3:0][3:0] a
   );
      logic [4:0][3:0] c;
      logic [3:0][3:0] r;
      logic [2:0]      n;
      logic [1:0]      m;
      logic            skip;
      c    = '0;
      r    = '0;
      n    = '0;
      m    = '0;
      skip = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (a[i] != 4'd0) begin
            c[n] = a[i];
            n    = n + 3'd1;
         end
      end
      // c[4] stays empty, so the last tile never pairs
      for (int i = 0; i < 4; i++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (c[i] != 4'd0) begin
            if (c[i] == c[i+1]) begin
               r[m] = c[i] + 4'd1;
               skip = 1'b1;
            end else begin
               r[m] = c[i];
            end
            m = m + 2'd1;
         end
      end
      return r;
   endfunction

   logic [3:0][3:0] ix;
   logic [3:0][3:0] line_in;
   logic [3:0][3:0] line_out;
   logic            line_chg;

   always_comb begin
      ix      = '0;
      line_in = '0;
      for (int p = 0; p < 4; p++) begin
         unique case (1'b1)
            dir[3]:  ix[p] = {k, 2'(p)};
            dir[0]:  ix[p] = {k, 2'(3 - p)};
            dir[2]:  ix[p] = {2'(p), k};
            dir[1]:  ix[p] = {2'(3 - p), k};
            default: ix[p] = 4'd0;
         endcase
         line_in[p] = grid[ix[p]];
      end
      line_out = slide_line(line_in);
      line_chg = (line_out != line_in);
   end

   logic       spawn_ok;
   logic [3:0] spawn_ix;
   logic [3:0] spawn_val;
   logic [3:0] t;

   always_comb begin
      spawn_ok = 1'b0;
      spawn_ix = lfsr[3:0];
      t        = 4'd0;
      for (int i = 0; i < 16; i++) begin
         t = lfsr[3:0] + 4'(i);
         if (!spawn_ok && grid[t] == 4'd0) begin
            spawn_ok = 1'b1;
            spawn_ix = t;
         end
      end
      spawn_val = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
   end

   logic has_win;
   logic has_empty;
   logic has_pair;

   always_comb begin
      has_win   = 1'b0;
      has_empty = 1'b0;
      has_pair  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (grid[i] == WIN)   has_win   = 1'b1;
         if (grid[i] == 4'd0)  has_empty = 1'b1;
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 3; c++) begin
            if (grid[r*4+c] == grid[r*4+c+1])
               has_pair = 1'b1;
         end
      end
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (grid[r*4+c] == grid[r*4+c+4])
               has_pair = 1'b1;
         end
      end
   end

   logic fb;
   logic onehot;
   logic accept;
   logic any_chg;

   assign fb      = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign onehot  = (bus.direction != 4'd0) &&
                    ((bus.direction & (bus.direction - 4'd1)) == 4'd0);
   assign accept  = onehot && (status == PLAYING) && armed;
   assign any_chg = changed | line_chg;

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= INIT0;
         grid      <= '0;
         status    <= PLAYING;
         busy      <= 1'b1;
         move_done <= 1'b0;
         moved     <= 1'b0;
         lfsr      <= SEED;
         armed     <= 1'b1;
         dir       <= '0;
         changed   <= 1'b0;
         from_move <= 1'b0;
         k         <= '0;
      end else begin
         lfsr      <= {fb, lfsr[15:1]};
         move_done <= 1'b0;
         if (bus.direction == 4'b0000)
            armed <= 1'b1;
         unique case (fsm)
            INIT0: begin
               if (spawn_ok) grid[spawn_ix] <= spawn_val;
               fsm <= INIT1;
            end
            INIT1: begin
               if (spawn_ok) grid[spawn_ix] <= spawn_val;
               busy <= 1'b0;
               fsm  <= IDLE;
            end
            IDLE: begin
               if (bus.load) begin
                  grid      <= bus.load_grid;
                  busy      <= 1'b1;
                  from_move <= 1'b0;
                  fsm       <= CHECK;
               end else if (accept) begin
                  dir     <= bus.direction;
                  armed   <= 1'b0;
                  changed <= 1'b0;
                  k       <= '0;
                  busy    <= 1'b1;
                  fsm     <= SLIDE;
               end
            end
            SLIDE: begin
               for (int p = 0; p < 4; p++)
                  grid[ix[p]] <= line_out[p];
               changed <= any_chg;
               k       <= k + 2'd1;
               if (k == 2'd3) begin
                  if (any_chg) begin
                     fsm <= SPAWN;
                  end else begin
                     move_done <= 1'b1;
                     moved     <= 1'b0;
                     busy      <= 1'b0;
                     fsm       <= IDLE;
                  end
               end
            end
            SPAWN: begin
               if (spawn_ok) grid[spawn_ix] <= spawn_val;
               from_move <= 1'b1;
               fsm       <= CHECK;
            end
            CHECK: begin
               if (has_win)
                  status <= WON;
               else if (!has_empty && !has_pair)
                  status <= LOST;
               else
                  status <= PLAYING;
               busy <= 1'b0;
               fsm  <= IDLE;
               if (from_move) begin
                  move_done <= 1'b1;
                  moved     <= 1'b1;
               end
            end
            default: fsm <= INIT0;
         endcase
      end
   end
endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer: merges, no-op, win, lose,
// input filtering and reset during a move.
module tb_move_sequencer;
   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   move_sequencer_if bus();

   move_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(
      input string       tag,
      input logic [63:0] obs,
      input logic [63:0] exp
   );
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0][3:0] row0(
      input logic [3:0] a, b, c, d
   );
      logic [15:0][3:0] g;
      g    = '0;
      g[0] = a;
      g[1] = b;
      g[2] = c;
      g[3] = d;
      return g;
   endfunction

   // nonzero cells outside keep; a cell above 2 adds 100
   function automatic int spawned(
      input logic [15:0][3:0] g,
      input logic [15:0]      keep
   );
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) begin
         if (!keep[i] && g[i] != 4'd0) begin
            if (g[i] > 4'd2) n += 100;
            n++;
         end
      end
      return n;
   endfunction

   task automatic do_load(input logic [15:0][3:0] g);
      bus.load_grid = g;
      bus.load      = 1'b1;
      step();
      bus.load = 1'b0;
      chk("load_grid", bus.grid, g);
      chk("load_busy", bus.busy, 1);
      step();
      chk("load_idle", bus.busy, 0);
   endtask

   task automatic do_move(
      input  logic [3:0] d,
      output int         cyc,
      output logic       mv
   );
      bus.direction = d;
      step();
      chk("accept_busy", bus.busy, 1);
      bus.direction = 4'd0;
      cyc = 0;
      mv  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (bus.move_done) begin
            cyc = i + 2;
            mv  = bus.moved;
            chk("done_busy", bus.busy, 0);
            break;
         end
      end
   endtask

   logic [15:0][3:0] g;
   logic [15:0][3:0] snap;
   int               cyc;
   logic             mv;
   int               bz;
   int               dn;

   initial begin
      bus.direction = 4'd0;
      bus.load      = 1'b0;
      bus.load_grid = '0;
      rst           = 1'b1;
      step();
      step();
      chk("rst_grid", bus.grid, 0);
      chk("rst_state", bus.state, 0);
      chk("rst_busy", bus.busy, 1);
      chk("rst_done", bus.move_done, 0);
      rst = 1'b0;
      step();
      chk("init0_busy", bus.busy, 1);
      step();
      chk("init_busy", bus.busy, 0);
      chk("init_tiles", spawned(bus.grid, 16'h0), 2);

      g = row0(1, 1, 2, 2);
      do_load(g);
      chk("pair_state0", bus.state, 0);
      do_move(4'b1000, cyc, mv);
      chk("pair_c0", bus.grid[0], 2);
      chk("pair_c1", bus.grid[1], 3);
      chk("pair_spawn", spawned(bus.grid, 16'h0003), 1);
      chk("pair_moved", mv, 1);
      chk("pair_lat", cyc, 7);
      chk("pair_state", bus.state, 0);

      g = row0(1, 1, 1, 0);
      do_load(g);
      do_move(4'b0001, cyc, mv);
      chk("right_c2", bus.grid[2], 1);
      chk("right_c3", bus.grid[3], 2);
      chk("right_spawn", spawned(bus.grid, 16'h000C), 1);
      chk("right_moved", mv, 1);

      g = row0(2, 2, 2, 2);
      do_load(g);
      do_move(4'b1000, cyc, mv);
      chk("quad_c0", bus.grid[0], 3);
      chk("quad_c1", bus.grid[1], 3);
      chk("quad_spawn", spawned(bus.grid, 16'h0003), 1);

      g = row0(1, 2, 3, 4);
      do_load(g);
      do_move(4'b1000, cyc, mv);
      chk("noop_grid", bus.grid, g);
      chk("noop_moved", mv, 0);
      chk("noop_lat", cyc, 5);

      bus.direction = 4'b0011;
      bz = 0;
      dn = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         bz += int'(bus.busy);
         dn += int'(bus.move_done);
      end
      bus.direction = 4'd0;
      chk("bad_dir_busy", bz, 0);
      chk("bad_dir_done", dn, 0);
      chk("bad_dir_grid", bus.grid, g);

      g = row0(1, 1, 0, 0);
      do_load(g);
      bus.direction = 4'b1000;
      dn = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         dn += int'(bus.move_done);
      end
      chk("hold_done", dn, 1);
      bus.direction = 4'b0100;
      bz = 0;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         bz += int'(bus.busy);
         dn += int'(bus.move_done);
      end
      chk("noarm_busy", bz, 0);
      chk("noarm_done", dn, 0);
      bus.direction = 4'd0;
      step();
      do_move(4'b0100, cyc, mv);
      chk("rearm_done", (cyc == 5 || cyc == 7), 1);

      g = row0(10, 10, 0, 0);
      do_load(g);
      do_move(4'b1000, cyc, mv);
      chk("win_c0", bus.grid[0], 11);
      chk("win_state", bus.state, 1);
      chk("win_moved", mv, 1);
      snap = bus.grid;
      bus.direction = 4'b0010;
      bz = 0;
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         bz += int'(bus.busy);
         dn += int'(bus.move_done);
      end
      bus.direction = 4'd0;
      chk("won_busy", bz, 0);
      chk("won_done", dn, 0);
      chk("won_grid", bus.grid, snap);

      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            g[r*4+c] = ((r + c) % 2 == 0) ? 4'd1 : 4'd2;
      step();
      bus.load_grid = g;
      bus.load      = 1'b1;
      step();
      bus.load = 1'b0;
      chk("lose_grid", bus.grid, g);
      chk("lose_early", bus.state, 1);
      step();
      chk("lose_state", bus.state, 2);
      chk("lose_idle", bus.busy, 0);
      bus.direction = 4'b1000;
      bz = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         bz += int'(bus.busy);
      end
      bus.direction = 4'd0;
      chk("lost_busy", bz, 0);
      chk("lost_grid", bus.grid, g);

      step();
      g = row0(1, 1, 0, 0);
      do_load(g);
      chk("reload_state", bus.state, 0);
      bus.direction = 4'b1000;
      step();
      bus.direction = 4'd0;
      step();
      rst = 1'b1;
      step();
      chk("mid_rst_grid", bus.grid, 0);
      chk("mid_rst_state", bus.state, 0);
      chk("mid_rst_busy", bus.busy, 1);
      chk("mid_rst_done", bus.move_done, 0);
      rst = 1'b0;
      dn = 0;
      step();
      dn += int'(bus.move_done);
      chk("mid_init0_busy", bus.busy, 1);
      step();
      dn += int'(bus.move_done);
      chk("mid_init_busy", bus.busy, 0);
      chk("mid_init_tiles", spawned(bus.grid, 16'h0), 2);
      chk("mid_no_done", dn, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
